// File: rtl/estagio_escrita_pkg.sv
// Load-type codes, queue entry layout and load-data formatting shared by the write-back stage.
package pacote_rv32i;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam int LARG_ENTRADA = 10;

  typedef struct packed {
    logic [4:0] rd;
    logic [2:0] funct3;
    logic [1:0] offset;
  } entrada_carga_t;

  // Unknown funct3 codes fall through to the word path.
  function automatic logic [31:0] formata_carga(input logic [2:0] funct3,
                                                input logic [1:0] offset,
                                                input logic [31:0] palavra);
    logic [7:0]  byte_sel;
    logic [15:0] meia_sel;
    byte_sel = palavra[8*offset +: 8];
    meia_sel = offset[1] ? palavra[31:16] : palavra[15:0];
    case (funct3)
      F3_LB:   formata_carga = {{24{byte_sel[7]}}, byte_sel};
      F3_LBU:  formata_carga = {24'd0, byte_sel};
      F3_LH:   formata_carga = {{16{meia_sel[15]}}, meia_sel};
      F3_LHU:  formata_carga = {16'd0, meia_sel};
      default: formata_carga = palavra;
    endcase
  endfunction

  function automatic logic desalinhado(input logic [2:0] funct3, input logic [1:0] offset);
    case (funct3)
      F3_LB, F3_LBU: desalinhado = 1'b0;
      F3_LH, F3_LHU: desalinhado = offset[0];
      default:       desalinhado = (offset != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/estagio_escrita_if.sv
// Bundle of ALU, load-issue, memory-response and register-file write signals of the write-back stage.
// Adds erro_desalinhado when ESCRITA_DESALINHADO_EN is defined.
interface estagio_escrita_if;
  logic        ula_valido;
  logic [4:0]  ula_rd;
  logic [31:0] ula_dado;
  logic        carga_emitir;
  logic [4:0]  carga_rd;
  logic [2:0]  carga_funct3;
  logic [1:0]  carga_offset;
  logic        carga_aceita;
  logic        mem_valido;
  logic [31:0] mem_dado;
  logic        mem_pronto;
  logic [31:0] reg_pendente;
  logic [4:0]  reg_destino;
  logic [31:0] dado_escrita;
  logic        habilitar_escrita;
`ifdef ESCRITA_DESALINHADO_EN
  logic        erro_desalinhado;

  modport master (
    output ula_valido, ula_rd, ula_dado, carga_emitir, carga_rd, carga_funct3, carga_offset,
           mem_valido, mem_dado,
    input  carga_aceita, mem_pronto, reg_pendente, reg_destino, dado_escrita, habilitar_escrita,
           erro_desalinhado
  );
  modport slave (
    input  ula_valido, ula_rd, ula_dado, carga_emitir, carga_rd, carga_funct3, carga_offset,
           mem_valido, mem_dado,
    output carga_aceita, mem_pronto, reg_pendente, reg_destino, dado_escrita, habilitar_escrita,
           erro_desalinhado
  );
`else
  modport master (
    output ula_valido, ula_rd, ula_dado, carga_emitir, carga_rd, carga_funct3, carga_offset,
           mem_valido, mem_dado,
    input  carga_aceita, mem_pronto, reg_pendente, reg_destino, dado_escrita, habilitar_escrita
  );
  modport slave (
    input  ula_valido, ula_rd, ula_dado, carga_emitir, carga_rd, carga_funct3, carga_offset,
           mem_valido, mem_dado,
    output carga_aceita, mem_pronto, reg_pendente, reg_destino, dado_escrita, habilitar_escrita
  );
`endif
endinterface

// File: rtl/estagio_escrita_fila_cargas.sv
// In-order queue of outstanding loads; pointers carry one extra wrap bit to tell full from empty.
module fila_cargas #(
  parameter int PROF = 4,
  parameter int LARG = 10
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push,
  input  logic            pop,
  input  logic [LARG-1:0] dado_entrada,
  output logic [LARG-1:0] dado_saida,
  output logic            cheia,
  output logic            vazia
);
  localparam int PW = $clog2(PROF);

  logic [PW:0]     ptr_esc;
  logic [PW:0]     ptr_lei;
  logic [LARG-1:0] mem [PROF];

  assign vazia      = (ptr_esc == ptr_lei);
  assign cheia      = (ptr_esc[PW] != ptr_lei[PW]) && (ptr_esc[PW-1:0] == ptr_lei[PW-1:0]);
  assign dado_saida = mem[ptr_lei[PW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_esc <= '0;
      ptr_lei <= '0;
    end else begin
      if (push && !cheia) ptr_esc <= ptr_esc + 1'b1;
      if (pop && !vazia)  ptr_lei <= ptr_lei + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !cheia) mem[ptr_esc[PW-1:0]] <= dado_entrada;
  end
endmodule

// File: rtl/estagio_escrita.sv
// RV32I write-back: merges ALU results with in-order load responses into the register-file write port.
// ESCRITA_DESALINHADO_EN adds erro_desalinhado and suppresses the write of misaligned loads.
module estagio_escrita
  import pacote_rv32i::*;
#(
  parameter int PROF_CARGAS = 4
) (
  input  logic              sinal_clk,
  input  logic              sinal_rst_n,
  estagio_escrita_if.slave  bus
);
  logic           cheia;
  logic           vazia;
  logic           push;
  logic           pop;
  logic [LARG_ENTRADA-1:0] saida_fila;
  entrada_carga_t cabeca;
  logic [31:0]    pendente;
  logic [31:0]    pendente_prox;
  logic [31:0]    dado_formatado;

  assign bus.carga_aceita = ~cheia & ~pendente[bus.carga_rd];
  assign bus.mem_pronto   = ~vazia & ~bus.ula_valido;
  assign push             = bus.carga_emitir & bus.carga_aceita;
  assign pop              = bus.mem_valido & bus.mem_pronto;
  assign cabeca           = entrada_carga_t'(saida_fila);
  assign dado_formatado   = formata_carga(cabeca.funct3, cabeca.offset, bus.mem_dado);
  assign bus.reg_pendente = pendente;

  fila_cargas #(.PROF(PROF_CARGAS), .LARG(LARG_ENTRADA)) u_fila (
    .clk          (sinal_clk),
    .rst_n        (sinal_rst_n),
    .push         (push),
    .pop          (pop),
    .dado_entrada ({bus.carga_rd, bus.carga_funct3, bus.carga_offset}),
    .dado_saida   (saida_fila),
    .cheia        (cheia),
    .vazia        (vazia)
  );

  // A same-cycle issue to the head rd is already refused, so clear-then-set never collides.
  always_comb begin
    pendente_prox = pendente;
    if (pop)  pendente_prox[cabeca.rd]   = 1'b0;
    if (push) pendente_prox[bus.carga_rd] = 1'b1;
    pendente_prox[0] = 1'b0;
  end

  always_ff @(posedge sinal_clk or negedge sinal_rst_n) begin
    if (!sinal_rst_n) begin
      pendente              <= '0;
      bus.habilitar_escrita <= 1'b0;
      bus.reg_destino       <= '0;
      bus.dado_escrita      <= '0;
`ifdef ESCRITA_DESALINHADO_EN
      bus.erro_desalinhado  <= 1'b0;
`endif
    end else begin
      pendente              <= pendente_prox;
      bus.habilitar_escrita <= 1'b0;
`ifdef ESCRITA_DESALINHADO_EN
      bus.erro_desalinhado  <= 1'b0;
`endif
      if (bus.ula_valido) begin
        bus.habilitar_escrita <= 1'b1;
        bus.reg_destino       <= bus.ula_rd;
        bus.dado_escrita      <= bus.ula_dado;
      end else if (pop) begin
`ifdef ESCRITA_DESALINHADO_EN
        if (desalinhado(cabeca.funct3, cabeca.offset)) begin
          bus.erro_desalinhado <= 1'b1;
        end else begin
          bus.habilitar_escrita <= 1'b1;
          bus.reg_destino       <= cabeca.rd;
          bus.dado_escrita      <= dado_formatado;
        end
`else
        bus.habilitar_escrita <= 1'b1;
        bus.reg_destino       <= cabeca.rd;
        bus.dado_escrita      <= dado_formatado;
`endif
      end
    end
  end
endmodule
